// File: rtl/dvi_scanout.sv
// Raster timing generator and two-stage pixel pipeline for the DVI transmitter.
// Pulls one frame-buffer word per active pixel and reports missing or unexpected data.
module dvi_scanout #(
  parameter int          H_ACTIVE        = 640,
  parameter int          H_FP            = 16,
  parameter int          H_SYNC          = 96,
  parameter int          H_BP            = 48,
  parameter int          V_ACTIVE        = 480,
  parameter int          V_FP            = 10,
  parameter int          V_SYNC          = 2,
  parameter int          V_BP            = 33,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000
) (
  input  logic        dvi_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clr_status,
  output logic        read_init,
  input  logic [31:0] iData,
  input  logic        iValid,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic        oDE,
  output logic        oHsync,
  output logic        oVsync,
  output logic        frame_start,
  output logic        underflow,
  output logic        spurious,
  output logic [15:0] underflow_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_0 = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_1 = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_0 = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_1 = 13'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;

  logic        s1_act_q, s1_act_d;
  logic        s1_hs_q, s1_hs_d;
  logic        s1_vs_q, s1_vs_d;
  logic        s1_first_q, s1_first_d;

  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;
  logic [23:0] rgb_q, rgb_d;
  logic        uf_q, uf_d;
  logic        sp_q, sp_d;
  logic [15:0] cnt_q, cnt_d;

  logic active, hs_n, vs_n, first;
  logic h_end, v_end;
  logic uf_evt, sp_evt;
  logic unused_bits;

  assign h_end  = (h_q == H_LAST);
  assign v_end  = (v_q == V_LAST);
  assign active = (state_q == RUN) && ({1'b0, h_q} < H_ACT) && ({1'b0, v_q} < V_ACT);
  assign hs_n   = !(({1'b0, h_q} >= H_SYNC_0) && ({1'b0, h_q} < H_SYNC_1));
  assign vs_n   = !(({1'b0, v_q} >= V_SYNC_0) && ({1'b0, v_q} < V_SYNC_1));
  assign first  = active && (h_q == 12'd0) && (v_q == 12'd0);

  assign read_init = active;

  // Enable is only honoured at the last pixel of the frame, so frames are never cut short.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        h_d = 12'd0;
        v_d = 12'd0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (h_end) begin
          h_d = 12'd0;
          if (v_end) begin
            v_d = 12'd0;
            if (!enable) state_d = IDLE;
          end else begin
            v_d = v_q + 12'd1;
          end
        end else begin
          h_d = h_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_act_d   = active;
    s1_hs_d    = hs_n || (state_q == IDLE);
    s1_vs_d    = vs_n || (state_q == IDLE);
    s1_first_d = first;
  end

  // The returned word lines up with the stage-1 copy of the request.
  always_comb begin
    uf_evt = s1_act_q && !iValid;
    sp_evt = !s1_act_q && iValid;
    de_d   = s1_act_q;
    hs_d   = s1_hs_q;
    vs_d   = s1_vs_q;
    fs_d   = s1_first_q;
    rgb_d  = 24'h000000;
    if (s1_act_q) begin
      rgb_d = iValid ? {iData[29:22], iData[19:12], iData[9:2]} : UNDERFLOW_COLOR;
    end
    uf_d = uf_evt || (uf_q && !clr_status);
    sp_d = sp_evt || (sp_q && !clr_status);
    if (clr_status) begin
      cnt_d = uf_evt ? 16'd1 : 16'd0;
    end else if (uf_evt && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge dvi_clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      h_q        <= 12'd0;
      v_q        <= 12'd0;
      s1_act_q   <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s1_first_q <= 1'b0;
      de_q       <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      fs_q       <= 1'b0;
      rgb_q      <= 24'h000000;
      uf_q       <= 1'b0;
      sp_q       <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      s1_act_q   <= s1_act_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s1_first_q <= s1_first_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      fs_q       <= fs_d;
      rgb_q      <= rgb_d;
      uf_q       <= uf_d;
      sp_q       <= sp_d;
      cnt_q      <= cnt_d;
    end
  end

  // Only the top 8 bits of each 10-bit channel reach the transmitter.
  assign unused_bits = ^{iData[31:30], iData[21:20], iData[11:10], iData[1:0]};

  assign oR            = rgb_q[23:16];
  assign oG            = rgb_q[15:8];
  assign oB            = rgb_q[7:0];
  assign oDE           = de_q;
  assign oHsync        = hs_q;
  assign oVsync        = vs_q;
  assign frame_start   = fs_q;
  assign underflow     = uf_q;
  assign spurious      = sp_q;
  assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_dvi_scanout.sv
// Bench for dvi_scanout: a small raster instance for timing, data and status,
// and a wide raster instance that starves its source to reach counter saturation.
module tb_dvi_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en1, clr1, ri1, iv1;
  logic [31:0] id1;
  logic [7:0]  r1, g1, b1;
  logic        de1, hs1, vs1, fs1, uf1, sp1;
  logic [15:0] cnt1;

  logic        rst2_n, en2, clr2, ri2, iv2;
  logic [31:0] id2;
  logic [7:0]  r2, g2, b2;
  logic        de2, hs2, vs2, fs2, uf2, sp2;
  logic [15:0] cnt2;

  localparam logic [23:0] UF_COLOR = 24'h123456;

  dvi_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .UNDERFLOW_COLOR(UF_COLOR)
  ) dut (
    .dvi_clk(clk), .reset_n(rst_n), .enable(en1), .clr_status(clr1),
    .read_init(ri1), .iData(id1), .iValid(iv1),
    .oR(r1), .oG(g1), .oB(b1), .oDE(de1), .oHsync(hs1), .oVsync(vs1),
    .frame_start(fs1), .underflow(uf1), .spurious(sp1), .underflow_cnt(cnt1)
  );

  dvi_scanout #(
    .H_ACTIVE(2048), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(40), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_sat (
    .dvi_clk(clk), .reset_n(rst2_n), .enable(en2), .clr_status(clr2),
    .read_init(ri2), .iData(id2), .iValid(iv2),
    .oR(r2), .oG(g2), .oB(b2), .oDE(de2), .oHsync(hs2), .oVsync(vs2),
    .frame_start(fs2), .underflow(uf2), .spurious(sp2), .underflow_cnt(cnt2)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vec[64];

  function automatic logic [31:0] pix_word(input int k);
    logic [7:0] n;
    n = 8'(k * 7 + 3);
    return {2'b00, n, 2'b11, ~n, 2'b01, n ^ 8'hA5, 2'b10};
  endfunction

  function automatic logic [23:0] pix_rgb(input int k);
    logic [7:0] n;
    n = 8'(k * 7 + 3);
    return {n, ~n, n ^ 8'hA5};
  endfunction

  // Source model: answers each request one cycle later from the vector table.
  int   req_idx  = 0;
  logic spur_req = 1'b0;

  initial begin
    logic        nv;
    logic [31:0] nd;
    iv1 = 1'b0;
    id1 = 32'h0;
    forever begin
      @(negedge clk);
      nv = 1'b0;
      nd = 32'h0;
      if (ri1) begin
        if (req_idx < 64) begin
          nv = vec[req_idx].valid;
          nd = vec[req_idx].data;
        end else begin
          nv = 1'b1;
          nd = 32'h0;
        end
        req_idx++;
      end
      @(posedge clk);
      #1;
      iv1 = nv | spur_req;
      id1 = spur_req ? 32'hFFFF_FFFF : nd;
    end
  end

  task automatic pixel_checker();
    int g;
    for (int k = 0; k < 64; k++) begin
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!de1 && g < 300);
      check($sformatf("pix%0d", k), {r1, g1, b1}, vec[k].exp_rgb);
    end
  endtask

  task automatic raster_monitor();
    int g, h, v, e_de, e_hs, e_vs, e_fs, n_de, n_fs;
    logic x_de, x_hs, x_vs, x_fs;
    g = 0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; n_de = 0; n_fs = 0;
    while (!fs1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    for (int o = 0; o < 240; o++) begin
      h = o % 15;
      v = (o / 15) % 8;
      x_de = (h < 8) && (v < 4);
      x_hs = !((h >= 10) && (h < 13));
      x_vs = !((v >= 5) && (v < 7));
      x_fs = (h == 0) && (v == 0);
      if (de1 !== x_de) e_de++;
      if (hs1 !== x_hs) e_hs++;
      if (vs1 !== x_vs) e_vs++;
      if (fs1 !== x_fs) e_fs++;
      if (de1) n_de++;
      if (fs1) n_fs++;
      if (o == 119) begin
        check("frame1_uf_cnt", cnt1, 16'd0);
        check("frame1_uf_flag", uf1, 1'b0);
      end
      @(negedge clk);
    end
    check("raster_de_errs", e_de, 0);
    check("raster_hs_errs", e_hs, 0);
    check("raster_vs_errs", e_vs, 0);
    check("raster_fs_errs", e_fs, 0);
    check("de_pulses_2frames", n_de, 64);
    check("frame_starts_2frames", n_fs, 2);
  endtask

  task automatic run_main();
    int bad, g, n_de, n_fs, n_ri;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ri1 !== 1'b0 || de1 !== 1'b0 || fs1 !== 1'b0 || hs1 !== 1'b1 || vs1 !== 1'b1 ||
          uf1 !== 1'b0 || sp1 !== 1'b0 || cnt1 !== 16'd0) bad++;
    end
    check("idle_100_cycles", bad, 0);

    @(posedge clk);
    #1 en1 = 1'b1;
    @(negedge clk);
    check("first_req_not_yet", ri1, 1'b0);
    @(negedge clk);
    check("first_req", ri1, 1'b1);

    fork
      pixel_checker();
      raster_monitor();
    join
    check("frame2_uf_flag", uf1, 1'b1);
    check("frame2_uf_cnt", cnt1, 16'd3);
    check("no_spurious_yet", sp1, 1'b0);

    // Spurious word during horizontal blanking, right after the last active pixel.
    g = 0;
    do begin @(negedge clk); g++; end while (!ri1 && g < 200);
    g = 0;
    do begin @(negedge clk); g++; end while (ri1 && g < 200);
    check("spur_window", ri1, 1'b0);
    spur_req = 1'b1;
    @(posedge clk);
    #2 spur_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("spur_flag", sp1, 1'b1);
    check("spur_rgb", {r1, g1, b1}, 24'h000000);
    check("spur_de", de1, 1'b0);
    check("spur_no_uf", cnt1, 16'd3);

    // Disable at line 2: the frame must finish, then no more requests.
    g = 0;
    do begin @(negedge clk); g++; end while (!fs1 && g < 400);
    n_de = 0; n_fs = 0; n_ri = 0;
    for (int o = 0; o < 330; o++) begin
      if (o == 30) en1 = 1'b0;
      if (de1) n_de++;
      if (fs1) n_fs++;
      if (o >= 120 && ri1) n_ri++;
      @(negedge clk);
    end
    check("disable_de_pulses", n_de, 32);
    check("disable_frame_starts", n_fs, 1);
    check("disable_no_requests", n_ri, 0);
    check("disable_idle_outputs", {de1, hs1, vs1}, 3'b011);

    // Reset at line 2 of a running frame.
    en1 = 1'b1;
    g = 0;
    do begin @(negedge clk); g++; end while (!fs1 && g < 400);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_ctrl", {ri1, de1, fs1, hs1, vs1}, 5'b00011);
    check("midreset_rgb", {r1, g1, b1}, 24'h000000);
    check("midreset_status", {uf1, sp1, cnt1}, 18'h0);
    en1   = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ri1 !== 1'b0 || de1 !== 1'b0 || fs1 !== 1'b0 || hs1 !== 1'b1 || vs1 !== 1'b1 ||
          {r1, g1, b1} !== 24'h0) bad++;
    end
    check("post_reset_quiet", bad, 0);
  endtask

  task automatic run_sat();
    int nde, g;
    nde = 0;
    g = 0;
    while (nde < 65540 && g < 80000) begin
      @(negedge clk);
      g++;
      if (de2) begin
        nde++;
        if (nde == 65534) check("sat_cnt_fffe", cnt2, 16'hFFFE);
      end
    end
    check("sat_pixels_seen", nde, 65540);
    check("sat_cnt_ffff", cnt2, 16'hFFFF);
    check("sat_flag", uf2, 1'b1);

    // Clear in a cycle whose stage-1 slot is blank.
    g = 0;
    while (ri2 !== 1'b0 && g < 10000) begin @(negedge clk); g++; end
    @(posedge clk);
    #1 clr2 = 1'b1;
    @(posedge clk);
    #1 clr2 = 1'b0;
    check("clr_noevt_cnt", cnt2, 16'd0);
    check("clr_noevt_flag", uf2, 1'b0);

    // Clear coincident with a missing pixel.
    @(negedge clk);
    g = 0;
    while (ri2 !== 1'b1 && g < 10000) begin @(negedge clk); g++; end
    @(posedge clk);
    #1 clr2 = 1'b1;
    @(posedge clk);
    #1 clr2 = 1'b0;
    check("clr_evt_cnt", cnt2, 16'd1);
    check("clr_evt_flag", uf2, 1'b1);
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    en1    = 1'b0;
    en2    = 1'b0;
    clr1   = 1'b0;
    clr2   = 1'b0;
    iv2    = 1'b0;
    id2    = 32'h0;

    for (int k = 0; k < 64; k++) begin
      vec[k].data    = pix_word(k);
      vec[k].valid   = 1'b1;
      vec[k].exp_rgb = pix_rgb(k);
    end
    vec[5]  = '{32'h3FF003FF, 1'b1, 24'hFF00FF};
    vec[33] = '{pix_word(33), 1'b0, UF_COLOR};
    vec[40] = '{pix_word(40), 1'b0, UF_COLOR};
    vec[58] = '{pix_word(58), 1'b0, UF_COLOR};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {ri1, de1, fs1, hs1, vs1}, 5'b00011);
    check("reset_rgb", {r1, g1, b1}, 24'h000000);
    check("reset_status", {uf1, sp1, cnt1}, 18'h0);
    check("reset_sat_inst", {ri2, de2, hs2, vs2, uf2, cnt2}, {5'b00110, 16'h0});

    rst_n  = 1'b1;
    rst2_n = 1'b1;
    en2    = 1'b1;

    fork
      run_main();
      run_sat();
    join

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
